db9md_pad_reader: RTL and testbench
===================================

# db9md_pad_reader

Scanner for Sega Mega Drive 3/6-button pads on the DB9 user-port splitter. It sits directly upstream of the core's joystick mux. It drives the splitter's port-select (`joy_split`) and the pads' SELECT line (`joy_mdsel`), and samples the six shared active-low data pins. It presents two debounced-by-frame, active-high 16-bit button words, `joystick1` and `joystick2`, which replace USB joystick words when SNAC DB9 mode is enabled.

## Interface
- `STEP_CYCLES`, default 480: clocks per SELECT phase (10 µs at 48 MHz); legal range ≥4.
- `IDLE_STEPS`, default 170: phases of SELECT-high gap after each port scan (≥1.6 ms, lets 6-button pad counters time out).
- `clk_sys`, in, 1: system clock (48 MHz); the only clock.
- `reset`, in, 1: synchronous, active-high.
- `joy_in`, in, 6: pad pins, active low. [0] pin1, [1] pin2, [2] pin3, [3] pin4, [4] pin6, [5] pin9.
- `joy_mdsel`, out, 1: pad SELECT (pin7).
- `joy_split`, out, 1: splitter port select; 0 = port 1, 1 = port 2.
- `joystick1`, out, 16: port-1 buttons, active high. [0] R, [1] L, [2] D, [3] U, [4] B, [5] C, [6] A, [7] Start, [8] Mode, [9] X, [10] Y, [11] Z, [15:12] 0.
- `joystick2`, out, 16: port-2 buttons, same layout.
- `joy_present`, out, 2: bit n set when a pad was detected on port n+1 in its last scan.
- `joy_six`, out, 2: bit n set when the port n+1 pad identified as 6-button in its last scan.

## Operation
- `joy_in` passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- A step counter runs 0..STEP_CYCLES-1. The "tick" is the cycle where the count equals STEP_CYCLES-1. State advances only on ticks.
- States are IDLE and P0..P7. In IDLE, `joy_mdsel`=1 for IDLE_STEPS ticks, then the FSM goes to P0.
- SELECT level per phase: P0/P2/P4/P6 drive 1; P1/P3/P5/P7 drive 0. This gives exactly 4 falling edges per port scan.
- Samples are taken on the tick ending the phase, into a per-scan shadow register:
  - P0: U,D,L,R ← pin1..pin4; B ← pin6; C ← pin9.
  - P1: A ← pin6; Start ← pin9. present ← pin3 low AND pin4 low.
  - P2, P3, P4: no sampling.
  - P5: six ← pin1..pin4 all low.
  - P6: if six, Z ← pin1, Y ← pin2, X ← pin3, Mode ← pin4.
  - P7: no sampling. Commit on the tick ending P7.
- Commit rules:
  - If present=0, the selected `joystick` word = 0.
  - Else, if six=0, bits [11:8] = 0.
  - Otherwise the shadow is copied to the selected port's `joystick` word.
  - `joy_present` and `joy_six` bits update at the same commit.
- After the P7 tick the FSM enters IDLE and `joy_split` toggles on that same edge. The port switch therefore happens only while `joy_mdsel`=1.
- Sequence: IDLE(split=0) → P0..P7 (port 1) → IDLE(split=1) → P0..P7 (port 2) → IDLE(split=0) …
- Pin logic is inverted (active low in, active high out). The unselected port's word holds its last committed value.

## Timing
- Reset values: `joy_mdsel`=1, `joy_split`=0, `joystick1`=`joystick2`=0, `joy_present`=`joy_six`=0. FSM = IDLE with step count 0, synchronizer and shadow cleared.
- After reset deassertion, the first P0 starts after IDLE_STEPS×STEP_CYCLES clocks.
- Each phase lasts exactly STEP_CYCLES clocks; `joy_mdsel` changes on the clock edge after each tick. The pads get STEP_CYCLES−3 clocks of settle before sampling (synchronizer takes 2).
- Port scan period: (IDLE_STEPS+8)×STEP_CYCLES clocks. Full two-port refresh takes twice that (≈3.56 ms at defaults).
- Output words change only on the cycle after a P7 tick. All 16 bits, the present bit and the six bit update atomically; there are no partial updates.
- Reset asserted in any state, including mid-phase, takes effect on the next edge: all outputs return to reset values and the in-progress scan is discarded. Reset held high keeps the block frozen in reset state.
- If a pad is hot-plugged mid-scan, that scan's result stands as sampled. The next scan of that port corrects it.

## Test plan
- Reset/startup, with STEP_CYCLES=8 and IDLE_STEPS=4: hold reset 3 cycles → all outputs at reset values. First `joy_mdsel` fall occurs 40 cycles after release (32 IDLE + 8 P0).
- 3-button pad model on port 1, A+Right held → after the first port-1 commit, `joystick1`=0x0041, `joy_present`[0]=1, `joy_six`[0]=0. `joystick2` stays 0x0000.
- 6-button pad model on port 2, X+Mode+Start held → `joystick2`=0x0380, `joy_six`[1]=1, `joy_present`[1]=1.
- No pad (all `joy_in` high) on both ports → `joystick1`=`joystick2`=0x0000, `joy_present`=0b00 after a full refresh.
- Reset asserted mid-P3 of the port-2 scan (with port-1 pad holding Up, already committed as 0x0008) → next cycle `joystick1`=0, `joy_mdsel`=1, `joy_split`=0. The scan restarts from IDLE.
- Protocol monitor over 10 refreshes:
  - exactly 4 `joy_mdsel` falling edges per port window;
  - SELECT-high gap between windows ≥ IDLE_STEPS×STEP_CYCLES;
  - `joy_split` toggles only while `joy_mdsel`=1, once per window.

Source files
------------

// File: rtl/db9md_pad_reader_if.sv
// db9md_pad_reader_if: DB9 splitter pins and decoded Mega Drive pad words
interface db9md_pad_reader_if;
    logic [5:0]  joy_in;
    logic        joy_mdsel;
    logic        joy_split;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic [1:0]  joy_present;
    logic [1:0]  joy_six;
    modport master (
        input  joy_in,
        output joy_mdsel, joy_split, joystick1, joystick2, joy_present, joy_six
    );
    modport slave (
        output joy_in,
        input  joy_mdsel, joy_split, joystick1, joystick2, joy_present, joy_six
    );
endinterface

// File: rtl/db9md_pad_reader.sv
// db9md_pad_reader: scans 3/6-button Mega Drive pads on both splitter ports
module db9md_pad_reader #(
    parameter int STEP_CYCLES = 480,
    parameter int IDLE_STEPS  = 170
) (
    input logic                  clk_sys,
    input logic                  reset,
    db9md_pad_reader_if.master   pad
);
    localparam int SW = $clog2(STEP_CYCLES);
    localparam int IW = $clog2(IDLE_STEPS + 1);

    typedef enum logic [3:0] {IDLE, P0, P1, P2, P3, P4, P5, P6, P7} state_t;

    state_t        state, nxt;
    logic [5:0]    sync1, sync2, s;
    logic [SW-1:0] step;
    logic [IW-1:0] idle_cnt;
    logic [11:0]   sh;
    logic          sh_present, sh_six, tick, idle_done;
    logic [15:0]   word;

    assign s         = ~sync2;
    assign tick      = step == SW'(STEP_CYCLES - 1);
    assign idle_done = idle_cnt == IW'(IDLE_STEPS - 1);
    assign word      = sh_present ? {4'd0, sh_six ? sh[11:8] : 4'd0, sh[7:0]} : 16'd0;

    always_comb
        nxt = state == IDLE ? (idle_done ? P0 : IDLE) :
              state == P7   ? IDLE : state_t'(state + 4'd1);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state           <= IDLE;
            sync1           <= '0;
            sync2           <= '0;
            step            <= '0;
            idle_cnt        <= '0;
            sh              <= '0;
            sh_present      <= 1'b0;
            sh_six          <= 1'b0;
            pad.joy_mdsel   <= 1'b1;
            pad.joy_split   <= 1'b0;
            pad.joystick1   <= '0;
            pad.joystick2   <= '0;
            pad.joy_present <= '0;
            pad.joy_six     <= '0;
        end else begin
            sync1 <= pad.joy_in;
            sync2 <= sync1;
            step  <= tick ? '0 : step + 1'b1;
            if (tick) begin
                state         <= nxt;
                idle_cnt      <= (state == IDLE && !idle_done) ? idle_cnt + 1'b1 : '0;
                pad.joy_mdsel <= nxt inside {IDLE, P0, P2, P4, P6};
                unique case (state)
                    P0: sh[5:0] <= {s[5], s[4], s[0], s[1], s[2], s[3]};
                    P1: begin
                        sh[7:6]    <= s[5:4];
                        sh_present <= s[2] & s[3];
                    end
                    P5: sh_six <= &s[3:0];
                    P6: if (sh_six) sh[11:8] <= {s[0], s[1], s[2], s[3]};
                    P7: begin
                        // switching ports here keeps the splitter change inside a SELECT-high gap
                        if (pad.joy_split) pad.joystick2 <= word;
                        else               pad.joystick1 <= word;
                        pad.joy_present[pad.joy_split] <= sh_present;
                        pad.joy_six[pad.joy_split]     <= sh_six;
                        pad.joy_split                  <= ~pad.joy_split;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_db9md_pad_reader.sv
// tb_db9md_pad_reader: pad models on both ports, commit scoreboard and SELECT protocol monitor
module tb_db9md_pad_reader;
    localparam int STEP = 8;
    localparam int IDLE = 4;

    typedef struct {
        logic [15:0] j1;
        logic [15:0] j2;
        logic [1:0]  pr;
        logic [1:0]  sx;
    } exp_t;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    int   checks  = 0;
    int   errors  = 0;
    exp_t q[$];

    int          ptype [2];
    logic [11:0] btn   [2];
    int          cnt   [2];
    int          hi    [2];
    logic        psel  [2];

    db9md_pad_reader_if bus ();

    db9md_pad_reader #(.STEP_CYCLES(STEP), .IDLE_STEPS(IDLE)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .pad     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    // pin levels a real pad drives, given its SELECT level and falling-edge count
    function automatic logic [5:0] pins(input int t, input logic [11:0] b, input logic sel, input int c);
        logic [5:0] p;
        if (t == 0) return 6'h3F;
        if (sel) p = (t == 6 && c == 3) ? {b[5], b[4], b[8], b[9], b[10], b[11]}
                                        : {b[5], b[4], b[0], b[1], b[2], b[3]};
        else     p = (t == 6 && c == 3) ? {b[7], b[6], 4'b1111} :
                     (t == 6 && c == 4) ? {b[7], b[6], 4'b0000} :
                                          {b[7], b[6], 2'b11, b[2], b[3]};
        return ~p;
    endfunction

    function automatic logic sel_of(input int n);
        return (int'(bus.joy_split) == n) ? bus.joy_mdsel : 1'b1;
    endfunction

    assign bus.joy_in = bus.joy_split ? pins(ptype[1], btn[1], sel_of(1), cnt[1])
                                      : pins(ptype[0], btn[0], sel_of(0), cnt[0]);

    initial for (int n = 0; n < 2; n++) begin
        cnt[n]  = 0;
        hi[n]   = 0;
        psel[n] = 1'b1;
    end

    always @(posedge clk_sys)
        for (int n = 0; n < 2; n++) begin
            psel[n] <= sel_of(n);
            if (psel[n] && !sel_of(n)) cnt[n] <= cnt[n] + 1;
            else if (sel_of(n) && hi[n] >= 20) cnt[n] <= 0;
            hi[n] <= sel_of(n) ? hi[n] + 1 : 0;
        end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    // scoreboard: a split toggle marks a commit for the port just scanned
    logic        m_split = 1'b0;
    logic [15:0] m_j1 = '0, m_j2 = '0;
    logic [1:0]  m_pr = '0, m_sx = '0;
    always @(negedge clk_sys) begin
        exp_t e;
        if (!reset) begin
            if (bus.joy_split != m_split) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_commit split=%b", bus.joy_split);
                end else begin
                    e = q.pop_front();
                    chk("joystick1", 32'(bus.joystick1), 32'(e.j1));
                    chk("joystick2", 32'(bus.joystick2), 32'(e.j2));
                    chk("joy_present", 32'(bus.joy_present), 32'(e.pr));
                    chk("joy_six", 32'(bus.joy_six), 32'(e.sx));
                end
            end else if (bus.joystick1 !== m_j1 || bus.joystick2 !== m_j2 ||
                         bus.joy_present !== m_pr || bus.joy_six !== m_sx) begin
                checks++;
                errors++;
                $display("FAIL stray_update j1=%h j2=%h pr=%b sx=%b required j1=%h j2=%h pr=%b sx=%b",
                         bus.joystick1, bus.joystick2, bus.joy_present, bus.joy_six, m_j1, m_j2, m_pr, m_sx);
            end
        end
        m_split = bus.joy_split;
        m_j1    = bus.joystick1;
        m_j2    = bus.joystick2;
        m_pr    = bus.joy_present;
        m_sx    = bus.joy_six;
    end

    // protocol monitor: four SELECT falls per window, long high gap, split moves only with SELECT high
    int   falls = 0, hirun = 0;
    logic p_md = 1'b1, p_split = 1'b0;
    always @(negedge clk_sys) begin
        if (reset) begin
            falls = 0;
            hirun = 0;
        end else begin
            if (p_md && !bus.joy_mdsel) begin
                if (falls == 0) chk("sel_gap_ok", 32'(hirun >= IDLE * STEP), 32'd1);
                falls++;
            end
            hirun = bus.joy_mdsel ? hirun + 1 : 0;
            if (bus.joy_split != p_split) begin
                chk("split_with_sel_high", 32'(bus.joy_mdsel), 32'd1);
                chk("falls_per_window", 32'(falls), 32'd4);
                falls = 0;
            end
        end
        p_md    = bus.joy_mdsel;
        p_split = bus.joy_split;
    end

    task automatic push(input logic [15:0] j1, input logic [15:0] j2, input logic [1:0] pr, input logic [1:0] sx);
        exp_t e;
        e.j1 = j1;
        e.j2 = j2;
        e.pr = pr;
        e.sx = sx;
        q.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() > 0 && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", q.size());
            q.delete();
        end
    endtask

    initial begin
        int n;
        logic pm;
        ptype[0] = 3; btn[0] = 12'h041;
        ptype[1] = 6; btn[1] = 12'h380;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("rst_mdsel", 32'(bus.joy_mdsel), 32'd1);
        chk("rst_split", 32'(bus.joy_split), 32'd0);
        chk("rst_j1", 32'(bus.joystick1), 32'd0);
        chk("rst_j2", 32'(bus.joystick2), 32'd0);
        chk("rst_present", 32'(bus.joy_present), 32'd0);
        chk("rst_six", 32'(bus.joy_six), 32'd0);

        push(16'h0041, 16'h0000, 2'b01, 2'b00);
        for (int i = 0; i < 3; i++) push(16'h0041, 16'h0380, 2'b11, 2'b10);
        reset = 1'b0;
        n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (bus.joy_mdsel && n < 200);
        chk("first_sel_fall", 32'(n), 32'd40);
        drain(2000);

        ptype[0] = 0;
        ptype[1] = 0;
        push(16'h0000, 16'h0380, 2'b10, 2'b10);
        push(16'h0000, 16'h0000, 2'b00, 2'b00);
        drain(1000);

        ptype[0] = 3; btn[0] = 12'h008;
        push(16'h0008, 16'h0000, 2'b01, 2'b00);
        push(16'h0008, 16'h0000, 2'b01, 2'b00);
        drain(1000);

        // reset three cycles into P3 of the port-2 scan
        push(16'h0008, 16'h0000, 2'b01, 2'b00);
        n = 0;
        while (!bus.joy_split && n < 1000) begin
            @(negedge clk_sys);
            n++;
        end
        chk("reach_port2", 32'(bus.joy_split), 32'd1);
        n = 0;
        pm = bus.joy_mdsel;
        for (int f = 0; f < 2 && n < 1000; ) begin
            @(negedge clk_sys);
            n++;
            if (pm && !bus.joy_mdsel) f++;
            pm = bus.joy_mdsel;
        end
        repeat (3) @(negedge clk_sys);
        chk("pre_rst_j1", 32'(bus.joystick1), 32'h0008);
        reset = 1'b1;
        @(negedge clk_sys);
        chk("midscan_j1", 32'(bus.joystick1), 32'd0);
        chk("midscan_mdsel", 32'(bus.joy_mdsel), 32'd1);
        chk("midscan_split", 32'(bus.joy_split), 32'd0);
        chk("midscan_present", 32'(bus.joy_present), 32'd0);
        ptype[0] = 3; btn[0] = 12'h041;
        ptype[1] = 6; btn[1] = 12'h380;
        @(negedge clk_sys);
        reset = 1'b0;

        // ten full refreshes with both pads fitted
        for (int i = 0; i < 20; i++)
            if (i == 0) push(16'h0041, 16'h0000, 2'b01, 2'b00);
            else        push(16'h0041, 16'h0380, 2'b11, 2'b10);
        drain(4000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
